// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: elastic, registered bitwise logic unit.
// An operator-selected bitwise function of two operands is computed at the input and
// carried through a DEPTH-stage valid/ready pipeline. Each stage stalls only when it
// is full and the stage after it cannot take its beat, so bubbles compress and full
// throughput is kept under a stalling consumer.

module logic_gate_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             s_all,
    output logic             s_any,
    output logic [CNT_W-1:0] res_cnt
);

    typedef enum logic [2:0] {
        OpAnd  = 3'b000,
        OpOr   = 3'b001,
        OpXor  = 3'b010,
        OpNand = 3'b011,
        OpNor  = 3'b100,
        OpXnor = 3'b101,
        OpAndn = 3'b110,
        OpPass = 3'b111
    } op_e;

    logic [WIDTH-1:0] res;
    logic [DEPTH:0]   rdy;

    logic [DEPTH-1:0] v_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] all_q;
    logic [DEPTH-1:0] any_q;

    logic [CNT_W-1:0] res_cnt_q;
    logic [CNT_W-1:0] res_cnt_d;

    // Operator decode on the incoming operands.
    always_comb begin
        res = '0;
        unique case (op_e'(op))
            OpAnd:  res = a & b;
            OpOr:   res = a | b;
            OpXor:  res = a ^ b;
            OpNand: res = ~(a & b);
            OpNor:  res = ~(a | b);
            OpXnor: res = ~(a ^ b);
            OpAndn: res = a & ~b;
            OpPass: res = a;
            default: res = '0;
        endcase
    end

    // Ready chain: a stage can load when it is empty or its occupant moves on this cycle.
    always_comb begin
        rdy = '0;
        rdy[DEPTH] = out_ready;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            rdy[k] = !v_q[k] || rdy[k+1];
        end
    end

    assign in_ready = rdy[0];

    // Stage registers: stage 0 captures the computed result, later stages copy forward.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            all_q <= '0;
            any_q <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                data_q[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                v_q[0] <= in_valid;
                // Data only captured on a real beat; an empty load keeps the old value.
                if (in_valid) begin
                    data_q[0] <= res;
                    all_q[0]  <= &res;
                    any_q[0]  <= |res;
                end
            end
            for (int k = 1; k < int'(DEPTH); k++) begin
                if (rdy[k]) begin
                    v_q[k]    <= v_q[k-1];
                    data_q[k] <= data_q[k-1];
                    all_q[k]  <= all_q[k-1];
                    any_q[k]  <= any_q[k-1];
                end
            end
        end
    end

    // Delivered-result counter, wraps naturally at 2^CNT_W.
    always_comb begin
        res_cnt_d = res_cnt_q;
        if (out_valid && out_ready) begin
            res_cnt_d = res_cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_cnt_q <= '0;
        end else begin
            res_cnt_q <= res_cnt_d;
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign s         = data_q[DEPTH-1];
    assign s_all     = all_q[DEPTH-1];
    assign s_any     = any_q[DEPTH-1];
    assign res_cnt   = res_cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe: the driver announces the expected result of the
// beat it presents, a monitor queues it on accept and checks it on delivery.

module tb_logic_gate_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 4;

    typedef struct {
        logic [WIDTH-1:0] s;
        int               cyc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             s_all;
    logic             s_any;
    logic [CNT_W-1:0] res_cnt;

    int checks = 0;
    int errors = 0;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] cur_exp   = '0;
    logic [CNT_W-1:0] cnt_m     = '0;
    bit               exact_lat = 0;
    bit               stall_prev = 0;
    logic [WIDTH-1:0] s_prev    = '0;
    int               cyc       = 0;

    logic_gate_pipe #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .s_all     (s_all),
        .s_any     (s_any),
        .res_cnt   (res_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [2:0] o,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~(x & y);
            3'd4: return ~(x | y);
            3'd5: return ~(x ^ y);
            3'd6: return x & ~y;
            default: return x;
        endcase
    endfunction

    // Monitor: samples 1 time unit before each posedge, when all inputs are settled.
    always @(negedge clk) begin
        exp_t e;
        #4;
        cyc++;
        if (rst) begin
            exp_q.delete();
            cnt_m      = '0;
            stall_prev = 0;
        end else begin
            chk("in_ready", 32'(in_ready),
                32'(out_ready || (exp_q.size() < int'(DEPTH))));
            chk("res_cnt", 32'(res_cnt), 32'(cnt_m));
            if (stall_prev) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_s", 32'(s), 32'(s_prev));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got s=%0h expected no beat (t=%0t)",
                             s, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("s", 32'(s), 32'(e.s));
                    chk("s_all", 32'(s_all), 32'(&e.s));
                    chk("s_any", 32'(s_any), 32'(|e.s));
                    if (exact_lat) chk("latency", 32'(cyc - e.cyc), 32'(DEPTH));
                end
                cnt_m = cnt_m + CNT_W'(1);
            end
            if (in_valid && in_ready) begin
                e.s   = cur_exp;
                e.cyc = cyc;
                exp_q.push_back(e);
            end
            stall_prev = out_valid && !out_ready;
            s_prev     = s;
        end
    end

    // Present a beat (called at a negedge) and hold it until it is accepted.
    task automatic send(input logic [2:0] o, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] e);
        int n;
        bit acc;
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        cur_exp  = e;
        n        = 0;
        acc      = 0;
        do begin
            #4;
            acc = in_ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
        end
    endtask

    task automatic reset_pulse();
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    logic [7:0] sweep_exp [8];

    initial begin
        sweep_exp = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hC0, 8'hF0};
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        op = 3'd0;
        a = 8'hFF;
        b = 8'hFF;

        // 1: reset held two cycles with in_valid high
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_s", 32'(s), 32'd0);
            chk("rst_res_cnt", 32'(res_cnt), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // 2: op sweep back to back, exact latency
        exact_lat = 1;
        for (int i = 0; i < 8; i++) begin
            send(3'(i), 8'hF0, 8'h3C, sweep_exp[i]);
        end
        // 3: reduction flags
        send(3'd0, 8'hFF, 8'hFF, 8'hFF);
        send(3'd2, 8'hFF, 8'hFF, 8'h00);
        drain(10);
        exact_lat = 0;

        // 4: backpressure with a full pipe
        reset_pulse();
        out_ready = 1'b0;
        send(3'd1, 8'h01, 8'h02, 8'h03);
        send(3'd2, 8'h0F, 8'hFF, 8'hF0);
        chk("bp_accepted", 32'(exp_q.size()), 32'd2);
        fork
            send(3'd0, 8'hAA, 8'h0F, 8'h0A);
            begin
                repeat (3) begin
                    #1;
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                    chk("bp_s_hold", 32'(s), 32'h03);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        send(3'd7, 8'h5A, 8'h00, 8'h5A);
        drain(10);
        #1;
        chk("bp_res_cnt", 32'(res_cnt), 32'd4);

        // 5: reset with beats in flight
        @(negedge clk);
        out_ready = 1'b0;
        send(3'd0, 8'hFF, 8'h0F, 8'h0F);
        send(3'd1, 8'h10, 8'h01, 8'h11);
        in_valid = 1'b0;
        reset_pulse();
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_res_cnt", 32'(res_cnt), 32'd0);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_rst_no_stale", 32'(out_valid), 32'd0);

        // 6: random valid/ready traffic, counter wraps many times
        begin
            bit last_acc = 1;
            for (int i = 0; i < 3000; i++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if (!in_valid || last_acc) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    op       = 3'($urandom_range(0, 7));
                    a        = 8'($urandom_range(0, 255));
                    b        = 8'($urandom_range(0, 255));
                    cur_exp  = model(op, a, b);
                end else if ($urandom_range(0, 15) == 0) begin
                    in_valid = 1'b0;
                end
                #4;
                last_acc = in_valid && in_ready;
                @(negedge clk);
            end
        end
        out_ready = 1'b1;
        drain(20);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so a stuck handshake can never hang the run.
    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish before 1000000");
        $fatal(1, "timeout");
    end

endmodule
